redux_dump: RTL
===============

REDUX_DUMP -- requirements
Module: redux_dump

Interface
REQ-001 Parameter HALT_OPCODE, default 8'h10, SHALL be the instruction value that ends program execution.
REQ-002 Parameter MEM_WORDS, default 256, SHALL be the number of data-RAM bytes dumped; the legal range is 1..256.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL be the cycle-counter width; it SHALL be a multiple of 8.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the reset input, synchronous and active-high.
REQ-006 instrucao  in  8  SHALL carry the CPU's current instruction byte.
REQ-007 reg_addr  out  2  SHALL be the register-bank read index; reg_data (in, 8) SHALL return bank[reg_addr] combinationally.
REQ-008 mem_addr  out  8  SHALL be the data-RAM read address; mem_data (in, 8) SHALL return ram[mem_addr] one cycle after the address is presented.
REQ-009 out_data  out  8  SHALL be the dump byte stream.
REQ-010 out_valid  out  1 / out_ready  in  1  SHALL form the stream handshake; a transfer occurs on an edge where both are high.
REQ-011 busy  out  1  SHALL be high while the dump is in progress; done  out  1  SHALL be high once the dump completes.

Function
REQ-012 The FSM SHALL have states IDLE, HDR, CNT, REGS, MFETCH, MSEND, (CSUM), DONE.
REQ-013 In IDLE, the cycle counter SHALL increment on each edge where instrucao != HALT_OPCODE, saturating at all-ones with no wrap.
REQ-014 On IDLE with instrucao == HALT_OPCODE, the counter SHALL freeze and the FSM SHALL move to HDR on that edge.
REQ-015 If the halt is seen on the first cycle after reset, the count SHALL be 0.
REQ-016 Stream order SHALL be: 8'hA5; the count in CNT_WIDTH/8 bytes, MSB first; R0..R3; MEM[0]..MEM[MEM_WORDS-1]; then the checksum if enabled.
REQ-017 While out_valid is high and out_ready is low, out_data SHALL be held stable.
REQ-017a out_valid SHALL never drop without a transfer, except on reset.
REQ-018 HDR, CNT and REGS bytes SHALL be emitted back-to-back, one per cycle, while out_ready stays high.
REQ-019 For each memory byte: MFETCH SHALL drive mem_addr for one cycle; MSEND SHALL capture mem_data into out_data with out_valid high and hold it until transferred.
REQ-019a Under constant out_ready, memory bytes SHALL therefore be emitted at most one per 2 cycles.
REQ-020 mem_addr SHALL stay at 0 outside MFETCH/MSEND, and reg_addr SHALL stay at 0 outside REGS.
REQ-021 After the final byte is transferred, the FSM SHALL enter DONE: busy=0, done=1, out_valid=0.
REQ-021a The FSM SHALL remain in DONE until reset; later halts SHALL be ignored.
REQ-022 busy SHALL be 1 in every state except IDLE and DONE.
REQ-023 If instrucao changes during the dump, the stream SHALL be unaffected.

Reset
REQ-024 On a reset edge, the FSM SHALL go to IDLE with counter=0, out_valid=0, out_data=0, busy=0, done=0, mem_addr=0 and reg_addr=0.
REQ-025 Reset SHALL take priority over all events; reset mid-dump aborts the dump, and out_valid SHALL be low on the next cycle.
REQ-026 instrucao SHALL be ignored on any edge where reset is high; a halt seen there SHALL not start a dump.

Configuration
REQ-027 Macro REDUX_DUMP_CHECKSUM_EN: when defined, a final CSUM byte SHALL equal the XOR of all previously emitted bytes, including the header.
REQ-027a When REDUX_DUMP_CHECKSUM_EN is undefined, the CSUM state and logic SHALL be absent and the stream SHALL end after MEM[MEM_WORDS-1].

Verification
REQ-028 Scenario: halt on the 1st post-reset cycle, out_ready=1 -> bytes A5,00,00,R0..R3,MEM... are emitted.
REQ-028a For that scenario, total beats = 263 with MEM_WORDS=256, or 264 with the macro on.
REQ-029 Scenario: 37 non-halt cycles, then instrucao=8'h10 -> count bytes 00,25; done=1 after the last transfer.
REQ-030 Scenario: out_ready toggled 1,0,0,1 during REGS with R1=8'h7F -> out_data stays 7F across the stall; no byte is duplicated or lost.
REQ-031 Scenario: CNT_WIDTH=8 with 300 cycles before halt -> count byte FF (saturated).
REQ-032 Scenario: reset asserted while emitting MEM[10] -> out_valid=0 next cycle and state IDLE.
REQ-032a After that reset, a fresh halt SHALL restart the dump from A5 with count 0.
REQ-033 Scenario: macro on, MEM_WORDS=1, regs 1,2,3,4, MEM[0]=8'h10, count 0 -> CSUM = A5^00^00^01^02^03^04^10 = 8'hB1.

Source files
------------

// File: rtl/redux_dump.sv
// redux_dump: counts cycles until a halt opcode, then streams a state dump.
// Optional trailing XOR checksum byte when REDUX_DUMP_CHECKSUM_EN is defined.
module redux_dump #(
  parameter logic [7:0] HALT_OPCODE = 8'h10,
  parameter int         MEM_WORDS   = 256,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instrucao,
  output logic [1:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int         NB       = CNT_WIDTH / 8;
  localparam logic [7:0] LAST_CNT = 8'(NB - 1);
  localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    REGS,
    MFETCH,
    MSEND,
`ifdef REDUX_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t               state, nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0]           cidx;
  logic [1:0]           ridx;
  logic [7:0]           midx;
  logic [7:0]           cbyte;
  logic                 fire;
`ifdef REDUX_DUMP_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  // Select the count byte at cidx, most significant byte first.
  always_comb begin
    cbyte = 8'h00;
    for (int i = 0; i < NB; i++)
      if (8'(i) == cidx)
        cbyte = cnt[8*(NB-1-i) +: 8];
  end

  // Next-state and stream outputs; every output is a function of state.
  always_comb begin
    nxt       = state;
    out_valid = 1'b0;
    out_data  = 8'h00;
    reg_addr  = 2'd0;
    mem_addr  = 8'h00;
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    unique case (state)
      IDLE: begin
        if (instrucao == HALT_OPCODE)
          nxt = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = 8'hA5;
        if (out_ready)
          nxt = CNT;
      end
      CNT: begin
        out_valid = 1'b1;
        out_data  = cbyte;
        if (out_ready && cidx == LAST_CNT)
          nxt = REGS;
      end
      REGS: begin
        out_valid = 1'b1;
        reg_addr  = ridx;
        out_data  = reg_data;
        if (out_ready && ridx == 2'd3)
          nxt = MFETCH;
      end
      MFETCH: begin
        mem_addr = midx;
        nxt      = MSEND;
      end
      MSEND: begin
        out_valid = 1'b1;
        mem_addr  = midx;
        out_data  = mem_data;
        if (out_ready) begin
          if (midx == LAST_MEM)
`ifdef REDUX_DUMP_CHECKSUM_EN
            nxt = CSUM;
`else
            nxt = DONE;
`endif
          else
            nxt = MFETCH;
        end
      end
`ifdef REDUX_DUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        if (out_ready)
          nxt = DONE;
      end
`endif
      DONE: begin
        nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign fire = out_valid && out_ready;

  // State register, saturating cycle counter and stream indices.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cidx  <= 8'h00;
      ridx  <= 2'd0;
      midx  <= 8'h00;
    end else begin
      state <= nxt;
      if (state == IDLE && instrucao != HALT_OPCODE && cnt != '1)
        cnt <= cnt + 1'b1;
      if (fire && state == CNT)
        cidx <= cidx + 8'd1;
      if (fire && state == REGS)
        ridx <= ridx + 2'd1;
      if (fire && state == MSEND)
        midx <= midx + 8'd1;
    end
  end

`ifdef REDUX_DUMP_CHECKSUM_EN
  // Running XOR of every byte that has left the stream.
  always_ff @(posedge clock) begin
    if (reset)
      csum <= 8'h00;
    else if (fire)
      csum <= csum ^ out_data;
  end
`endif

endmodule
